// File: rtl/axi_slave_rw_arbiter_if.sv
// Handshake bundle between the AW/AR slave channel modules and the memory arbiter.
// The channel side uses the master modport; the arbiter uses the slave modport.
interface axi_slave_rw_arbiter_if;
   logic aw_req;
   logic ar_req;
   logic aw_hs;
   logic ar_hs;
   logic w_done;
   logic b_done;
   logic r_done;
   logic aw_grant;
   logic ar_grant;
   logic mem_sel;
   logic mem_busy;
   logic timeout_err;

   modport master (
      output aw_req, ar_req, aw_hs, ar_hs, w_done, b_done, r_done,
      input  aw_grant, ar_grant, mem_sel, mem_busy, timeout_err
   );

   modport slave (
      input  aw_req, ar_req, aw_hs, ar_hs, w_done, b_done, r_done,
      output aw_grant, ar_grant, mem_sel, mem_busy, timeout_err
   );
endinterface

// File: rtl/axi_slave_rw_arbiter.sv
// Single-port data memory arbiter between the AXI slave write and read channel modules.
// Grants one address accept at a time and holds memory ownership for the whole burst.
module axi_slave_rw_arbiter #(
   parameter int unsigned PRIORITY_MODE = 0,
   parameter int unsigned WAIT_BRESP    = 1,
   parameter int unsigned GRANT_TIMEOUT = 16,
   parameter int unsigned TO_CNT_WIDTH  = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   axi_slave_rw_arbiter_if.slave arb
);

   localparam bit                      TO_EN   = (GRANT_TIMEOUT != 0);
   localparam int unsigned             TO_LAST = (GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1;
   localparam logic [TO_CNT_WIDTH-1:0] TO_LAST_C = TO_CNT_WIDTH'(TO_LAST);
   localparam bit                      HOLD_B  = (WAIT_BRESP != 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_GRANT = 3'd1,
      W_BUSY  = 3'd2,
      W_RESP  = 3'd3,
      R_GRANT = 3'd4,
      R_BUSY  = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    last_rd_q, last_rd_d;
   logic [TO_CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
   logic                    pick_w;
   logic                    to_hit;
   logic                    aw_grant_q, aw_grant_d;
   logic                    ar_grant_q, ar_grant_d;
   logic                    mem_sel_q, mem_sel_d;
   logic                    mem_busy_q, mem_busy_d;
   logic                    timeout_err_q, timeout_err_d;

   // State, owner history, timeout counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_rd_q     <= 1'b1;
         to_cnt_q      <= '0;
         aw_grant_q    <= 1'b0;
         ar_grant_q    <= 1'b0;
         mem_sel_q     <= 1'b0;
         mem_busy_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_rd_q     <= last_rd_d;
         to_cnt_q      <= to_cnt_d;
         aw_grant_q    <= aw_grant_d;
         ar_grant_q    <= ar_grant_d;
         mem_sel_q     <= mem_sel_d;
         mem_busy_q    <= mem_busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next state, owner update, timeout and next output values
   always_comb begin
      state_d       = state_q;
      last_rd_d     = last_rd_q;
      to_cnt_d      = '0;
      timeout_err_d = 1'b0;
      to_hit        = TO_EN && (to_cnt_q == TO_LAST_C);

      unique case (PRIORITY_MODE)
         1:       pick_w = 1'b1;
         2:       pick_w = 1'b0;
         default: pick_w = last_rd_q;
      endcase

      unique case (state_q)
         IDLE: begin
            if (arb.aw_req && arb.ar_req) begin
               state_d = pick_w ? W_GRANT : R_GRANT;
            end else if (arb.aw_req) begin
               state_d = W_GRANT;
            end else if (arb.ar_req) begin
               state_d = R_GRANT;
            end
         end
         W_GRANT: begin
            // A handshake on the expiry cycle takes precedence over the timeout
            if (arb.aw_hs) begin
               if (arb.w_done) begin
                  if (HOLD_B) begin
                     state_d = W_RESP;
                  end else begin
                     state_d   = IDLE;
                     last_rd_d = 1'b0;
                  end
               end else begin
                  state_d = W_BUSY;
               end
            end else if (to_hit) begin
               state_d       = IDLE;
               last_rd_d     = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
            end
         end
         W_BUSY: begin
            if (arb.w_done) begin
               if (HOLD_B && !arb.b_done) begin
                  state_d = W_RESP;
               end else begin
                  state_d   = IDLE;
                  last_rd_d = 1'b0;
               end
            end
         end
         W_RESP: begin
            if (arb.b_done) begin
               state_d   = IDLE;
               last_rd_d = 1'b0;
            end
         end
         R_GRANT: begin
            if (arb.ar_hs) begin
               if (arb.r_done) begin
                  state_d   = IDLE;
                  last_rd_d = 1'b1;
               end else begin
                  state_d = R_BUSY;
               end
            end else if (to_hit) begin
               state_d       = IDLE;
               last_rd_d     = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
            end
         end
         R_BUSY: begin
            if (arb.r_done) begin
               state_d   = IDLE;
               last_rd_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      aw_grant_d = (state_d == W_GRANT);
      ar_grant_d = (state_d == R_GRANT);
      mem_busy_d = (state_d == W_BUSY) || (state_d == W_RESP) || (state_d == R_BUSY);
      // mem_sel keeps its last value through IDLE so the mux does not toggle needlessly
      if ((state_d == R_GRANT) || (state_d == R_BUSY)) begin
         mem_sel_d = 1'b1;
      end else if (state_d == IDLE) begin
         mem_sel_d = mem_sel_q;
      end else begin
         mem_sel_d = 1'b0;
      end
   end

   assign arb.aw_grant    = aw_grant_q;
   assign arb.ar_grant    = ar_grant_q;
   assign arb.mem_sel     = mem_sel_q;
   assign arb.mem_busy    = mem_busy_q;
   assign arb.timeout_err = timeout_err_q;

endmodule
